// File: rtl/mc_control_fsm_if.sv
// Handshake/control bundle between the multi-cycle sequencer and the MIPS datapath.
// The slave modport is the sequencer side; master is the datapath/IR side.
interface mc_control_fsm_if #(
  parameter int unsigned OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           PCWrite;
  logic           PCWriteCond;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           MemtoReg;
  logic           RegDst;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUOp;
  logic [1:0]     PCSource;
  logic           illegal_op;
  logic           mem_timeout;
  logic [3:0]     state_dbg;

  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_timeout, state_dbg
  );

  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_timeout, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory-ready stalls.
// Optional MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mc_control_fsm #(
  parameter int unsigned OPW         = 6,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.slave    bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  localparam logic [OPW-1:0] OpRtype = OPW'(6'b000000);
  localparam logic [OPW-1:0] OpJ     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OpBeq   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OpAddi  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OpLw    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OpSw    = OPW'(6'b101011);

  localparam logic [3:0] WaitLimit = 4'(MEM_TIMEOUT);
  localparam bit         TimeoutEn = (MEM_TIMEOUT != 0);

  state_e     r_state;
  logic [3:0] r_wait_cnt;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_legal;
  state_e     w_dec_next;

  assign w_wait_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  // Ready wins: the abort only fires when the limit is reached with mem_ready still low.
  assign w_timeout    = TimeoutEn && w_wait_state && !bus.mem_ready && (r_wait_cnt == WaitLimit);

  always_comb begin
    w_dec_next = StFetch;
    w_legal    = 1'b1;
    case (bus.opcode)
      OpLw, OpSw: w_dec_next = StMemAdr;
      OpRtype:    w_dec_next = StExec;
      OpBeq:      w_dec_next = StBranch;
      OpJ:        w_dec_next = StJump;
      OpAddi:     w_dec_next = StAddiEx;
      default:    w_legal    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
    end else begin
      // Counter only survives while stalled in the same wait state; saturates if unbounded.
      if (w_wait_state && !bus.mem_ready && !w_timeout) begin
        r_wait_cnt <= (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      case (r_state)
        StFetch:  if (bus.mem_ready) r_state <= StDecode;
        StDecode: r_state <= w_dec_next;
        StMemAdr: r_state <= (bus.opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd: begin
          if (bus.mem_ready)  r_state <= StMemWb;
          else if (w_timeout) r_state <= StFetch;
        end
        StMemWr:  if (bus.mem_ready || w_timeout) r_state <= StFetch;
        StExec:   r_state <= StRwb;
        StAddiEx: r_state <= StAddiWb;
        default:  r_state <= StFetch;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    case (r_state)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      StDecode: bus.ALUSrcB = 2'b11;
      StMemAdr, StAddiEx: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      StMemRd: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      StMemWr: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      StExec: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      StRwb: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      StBranch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      StJump: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      StAddiWb: bus.RegWrite = 1'b1;
      default: ;
    endcase
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.MemRead     = 1'b0;
    end
  end

  assign bus.illegal_op  = !reset && (r_state == StDecode) && !w_legal;
  assign bus.mem_timeout = !reset && w_timeout;
  assign bus.state_dbg   = r_state;

`ifdef MC_PERF_CNT_EN
  logic w_instr_done;

  // Completed instructions only; timeouts and illegal opcodes also land in FETCH but don't count.
  assign w_instr_done = (r_state == StMemWb) || (r_state == StRwb) || (r_state == StBranch) ||
                        (r_state == StJump) || (r_state == StAddiWb) ||
                        ((r_state == StMemWr) && bus.mem_ready);

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus randomized instruction streams
// compared against an instruction-level trace model.
module tb_mc_control_fsm;

  localparam int TO = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct {
    int   st;
    logic rdy;
    logic ill;
    logic to;
    logic samp;
  } cyc_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   m_cycles;
  int   m_instr;

  mc_control_fsm_if #(.OPW(6)) bus ();

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  mc_control_fsm #(.OPW(6), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );
`else
  mc_control_fsm #(.OPW(6), .MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  logic [18:0] act_out;
  logic [5:0]  act_en;
  assign act_out = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op, bus.mem_timeout};
  assign act_en  = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                    bus.MemRead};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs for one cycle, straight from the per-step control table.
  function automatic logic [18:0] spec_out(int st, logic rdy, logic ill, logic to);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill, to};
  endfunction

  // Builds the expected cycle trace of one instruction, then drives and checks it cycle by cycle.
  // fw/mw are the number of not-ready cycles in FETCH and in the data access.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    cyc_t q[$];
    bit   done;
    bit   aborted;
    logic [18:0] exp;
    done = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < fw && i < TO; i++) q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0});
    if (fw > TO) begin
      q.push_back('{0, 1'b0, 1'b0, 1'b1, 1'b0});
      aborted = 1'b1;
    end else begin
      q.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    if (!aborted) begin
      q.push_back('{1, 1'($urandom), !(op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW}),
                    1'b0, 1'b1});
      case (op)
        OP_LW, OP_SW: begin
          int mst;
          mst = (op == OP_LW) ? 3 : 5;
          q.push_back('{2, 1'($urandom), 1'b0, 1'b0, 1'b1});
          for (int i = 0; i < mw && i < TO; i++) q.push_back('{mst, 1'b0, 1'b0, 1'b0, 1'b0});
          if (mw > TO) begin
            q.push_back('{mst, 1'b0, 1'b0, 1'b1, 1'b0});
          end else begin
            q.push_back('{mst, 1'b1, 1'b0, 1'b0, 1'b0});
            if (op == OP_LW) q.push_back('{4, 1'($urandom), 1'b0, 1'b0, 1'b0});
            done = 1'b1;
          end
        end
        OP_R: begin
          q.push_back('{6, 1'($urandom), 1'b0, 1'b0, 1'b0});
          q.push_back('{7, 1'($urandom), 1'b0, 1'b0, 1'b0});
          done = 1'b1;
        end
        OP_BEQ: begin
          q.push_back('{8, 1'($urandom), 1'b0, 1'b0, 1'b0});
          done = 1'b1;
        end
        OP_J: begin
          q.push_back('{9, 1'($urandom), 1'b0, 1'b0, 1'b0});
          done = 1'b1;
        end
        OP_ADDI: begin
          q.push_back('{10, 1'($urandom), 1'b0, 1'b0, 1'b0});
          q.push_back('{11, 1'($urandom), 1'b0, 1'b0, 1'b0});
          done = 1'b1;
        end
        default: ;
      endcase
    end
    foreach (q[k]) begin
      bus.mem_ready = q[k].rdy;
      bus.opcode    = q[k].samp ? op : 6'($urandom);
      #1;
      exp = spec_out(q[k].st, q[k].rdy, q[k].ill, q[k].to);
      n_tests++;
      if (bus.state_dbg !== 4'(q[k].st) || act_out !== exp) begin
        n_fail++;
        $display("FAIL %s op=%b cyc %0d: state=%0d outs=%05h, expected state=%0d outs=%05h",
                 name, op, k, bus.state_dbg, act_out, q[k].st, exp);
      end
      @(negedge clk);
    end
    m_cycles += q.size();
    if (done) m_instr++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_cycles = 0;
    m_instr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    #1;
    n_tests++;
    if (act_en !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_enables_early: enables=%b, expected 000000", act_en);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.state_dbg !== 4'd0 || act_en !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d enables=%b, expected state=0 enables=000000",
               bus.state_dbg, act_en);
    end
    reset = 1'b0;
    m_cycles = 0;
    m_instr = 0;
  endtask

  task automatic test_rtype();
    run_instr("rtype", OP_R, 0, 0);
    run_instr("addi", OP_ADDI, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", OP_LW, 0, 3);
    run_instr("sw", OP_SW, 0, 0);
  endtask

  task automatic test_branch_jump();
    run_instr("beq", OP_BEQ, 0, 0);
    run_instr("jump", OP_J, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'b111111, 0, 0);
    run_instr("after_illegal", OP_R, 1, 0);
  endtask

  task automatic test_timeout();
    run_instr("fetch_timeout", OP_R, TO + 1, 0);
    run_instr("lw_timeout", OP_LW, 0, TO + 1);
    run_instr("sw_timeout", OP_SW, 2, TO + 1);
    run_instr("ready_wins", OP_SW, TO, TO);
    run_instr("after_timeout", OP_R, 0, 0);
  endtask

  task automatic test_reset_in_memwr();
    int   st_seq[5];
    logic rdy_seq[5];
    st_seq  = '{0, 1, 2, 5, 5};
    rdy_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy_seq[i];
      bus.opcode = OP_SW;
      #1;
      n_tests++;
      if (bus.state_dbg !== 4'(st_seq[i])) begin
        n_fail++;
        $display("FAIL memwr_approach cyc %0d: state=%0d, expected %0d", i, bus.state_dbg,
                 st_seq[i]);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.MemWrite !== 1'b0 || act_en !== 6'b0) begin
      n_fail++;
      $display("FAIL memwr_reset_cycle: MemWrite=%b enables=%b, expected 0 and 000000",
               bus.MemWrite, act_en);
    end
    @(negedge clk);
    reset = 1'b0;
    m_cycles = 0;
    m_instr = 0;
    n_tests++;
    if (bus.state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL memwr_reset_state: state=%0d, expected 0", bus.state_dbg);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, 6'b0};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b0 && $urandom_range(0, 1) == 1) op = 6'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      run_instr("random", op, fw, mw);
    end
`ifdef MC_PERF_CNT_EN
    n_tests++;
    if (cycle_cnt !== 32'(m_cycles) || instr_cnt !== 32'(m_instr)) begin
      n_fail++;
      $display("FAIL random_perf: cycle_cnt=%0d instr_cnt=%0d, expected %0d and %0d",
               cycle_cnt, instr_cnt, m_cycles, m_instr);
    end
`endif
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) run_instr("perf_rtype", OP_R, 0, 0);
    n_tests++;
    if (cycle_cnt !== 32'd12 || instr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_three_rtype: cycle_cnt=%0d instr_cnt=%0d, expected 12 and 3",
               cycle_cnt, instr_cnt);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_cycles = 0;
    m_instr = 0;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_in_memwr();
    test_random();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
